// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads one instruction word at a time over a req/ack
// handshake and computes the next PC when the held instruction retires.
//
// state | meaning
// IDLE  | post-reset, no request; fetch starts next cycle
// FETCH | imem_req high at pc, waiting for imem_ack
// HOLD  | instruction held and valid, waiting for instr_accept
// ERR   | imem_ack timed out; stuck until rst
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_count,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state;
    state_t      state_next;
    logic [31:0] wait_cnt;
    logic        fetch_done;
    logic        fetch_timeout;
    logic        retire;
    logic [31:0] next_pc;
    logic [31:0] branch_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch_done    = 1'b0;
        fetch_timeout = 1'b0;
        retire        = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                // an ack on the final allowed cycle still counts as a good fetch
                if (imem_ack) begin
                    state_next = HOLD;
                    fetch_done = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_LAST)) begin
                    state_next    = ERR;
                    fetch_timeout = 1'b1;
                end
            end
            HOLD: begin
                if (instr_accept) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            ERR: state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= 32'd0;
            wait_cnt     <= 32'd0;
            retire_count <= 32'd0;
            fetch_err    <= 1'b0;
        end else begin
            if (fetch_done) begin
                instr    <= imem_rdata;
                wait_cnt <= 32'd0;
            end else if (state == FETCH) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (fetch_timeout) begin
                fetch_err <= 1'b1;
            end
            if (retire) begin
                pc           <= next_pc;
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    assign imem_req    = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign imem_addr   = pc;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: default instance plus a second one with
// RESET_PC at the top of memory and the timeout disabled.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_accept = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retire_count;
    logic [5:0]  opcode, funct;

    logic        imem_req2, instr_valid2, fetch_err2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus42, retire_count2;
    logic [5:0]  opcode2, funct2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
        .instr_accept(instr_accept), .pcsrc(pcsrc), .jump(jump), .pc(pc),
        .pc_plus4(pc_plus4), .retire_count(retire_count), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(0)) dut_top (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2),
        .opcode(opcode2), .funct(funct2), .instr_valid(instr_valid2),
        .instr_accept(instr_accept), .pcsrc(pcsrc), .jump(jump), .pc(pc2),
        .pc_plus4(pc_plus42), .retire_count(retire_count2), .fetch_err(fetch_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; instr_accept = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin errors++;
            $display("FAIL reset_ctrl: req/valid/err=%b expected 000", {imem_req, instr_valid, fetch_err}); end
        checks++; if (pc !== 32'h0040_0000) begin errors++;
            $display("FAIL reset_pc: got %h expected 00400000", pc); end
        checks++; if ({instr, retire_count} !== 64'd0) begin errors++;
            $display("FAIL reset_instr_cnt: instr=%h retire=%0d expected 0/0", instr, retire_count); end
        checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL reset_pc_top: got %h expected fffffffc", pc2); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++;
            $display("FAIL idle_to_fetch: req=%b addr=%h expected 1/00400000", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020; instr_accept = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || pc !== 32'h0040_0000 + 32'(4 * i)) begin errors++;
                $display("FAIL seq_hold%0d: valid=%b pc=%h expected 1/%h", i, instr_valid, pc, 32'h0040_0000 + 32'(4 * i)); end
            checks++; if (instr !== 32'h20 || opcode !== 6'h00 || funct !== 6'h20 || pc_plus4 !== pc + 32'd4) begin errors++;
                $display("FAIL seq_fields%0d: instr=%h op=%h fn=%h pc4=%h", i, instr, opcode, funct, pc_plus4); end
            tick();
            checks++; if (instr_valid !== 1'b0 || retire_count !== 32'(i + 1)) begin errors++;
                $display("FAIL seq_retire%0d: valid=%b retire=%0d expected 0/%0d", i, instr_valid, retire_count, i + 1); end
        end
        instr_accept = 1'b0;
    endtask

    task automatic run_branch(input logic [31:0] word, input logic [31:0] exp_addr);
        do_reset();
        imem_ack = 1'b1; imem_rdata = word;
        tick(); tick();
        checks++; if (opcode !== 6'h04) begin errors++;
            $display("FAIL beq_opcode: got %h expected 04", opcode); end
        imem_ack = 1'b0; pcsrc = 1'b1;
        tick();
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h0040_0000) begin errors++;
            $display("FAIL pcsrc_no_accept: valid=%b pc=%h expected 1/00400000", instr_valid, pc); end
        instr_accept = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr || retire_count !== 32'd1) begin errors++;
            $display("FAIL branch_target: req=%b addr=%h retire=%0d expected 1/%h/1", imem_req, imem_addr, retire_count, exp_addr); end
        instr_accept = 1'b0; pcsrc = 1'b0;
    endtask

    task automatic test_branch();
        run_branch(32'h1000_0003, 32'h0040_0010);
        run_branch(32'h1000_FFFF, 32'h0040_0000);
    endtask

    task automatic test_jump();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0810_0008;
        tick(); tick();
        imem_ack = 1'b0; jump = 1'b1; pcsrc = 1'b1; instr_accept = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h0040_0020) begin errors++;
            $display("FAIL jump_priority: addr=%h expected 00400020", imem_addr); end
        jump = 1'b0; pcsrc = 1'b0; instr_accept = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        repeat (15) tick();
        checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++;
            $display("FAIL wait15: req=%b err=%b expected 1/0", imem_req, fetch_err); end
        imem_ack = 1'b1; imem_rdata = 32'h20;
        tick();
        checks++; if (instr_valid !== 1'b1 || fetch_err !== 1'b0) begin errors++;
            $display("FAIL ack_at_limit: valid=%b err=%b expected 1/0", instr_valid, fetch_err); end
        imem_ack = 1'b0; instr_accept = 1'b1;
        tick();
        instr_accept = 1'b0;
        repeat (15) tick();
        checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++;
            $display("FAIL wait15b: req=%b err=%b expected 1/0", imem_req, fetch_err); end
        tick();
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL timeout: err=%b req=%b valid=%b expected 1/0/0", fetch_err, imem_req, instr_valid); end
        checks++; if (fetch_err2 !== 1'b0 || imem_req2 !== 1'b1) begin errors++;
            $display("FAIL no_timeout_when_0: err=%b req=%b expected 0/1", fetch_err2, imem_req2); end
        imem_ack = 1'b1; instr_accept = 1'b1; pcsrc = 1'b1;
        repeat (3) tick();
        checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                      pc !== 32'h0040_0004 || retire_count !== 32'd1) begin errors++;
            $display("FAIL err_sticky: err=%b req=%b valid=%b pc=%h retire=%0d expected 1/0/0/00400004/1",
                     fetch_err, imem_req, instr_valid, pc, retire_count); end
        do_reset();
        checks++; if (pc !== 32'h0040_0000 || fetch_err !== 1'b0) begin errors++;
            $display("FAIL err_reset: pc=%h err=%b expected 00400000/0", pc, fetch_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h20; instr_accept = 1'b1;
        tick(); tick();
        checks++; if (pc_plus42 !== 32'd0) begin errors++;
            $display("FAIL wrap_pc4: got %h expected 00000000", pc_plus42); end
        tick();
        checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'd0) begin errors++;
            $display("FAIL wrap_addr: req=%b addr=%h expected 1/00000000", imem_req2, imem_addr2); end
        instr_accept = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h20; instr_accept = 1'b1;
        repeat (4) tick();
        checks++; if (instr_valid !== 1'b1 || retire_count !== 32'd1) begin errors++;
            $display("FAIL pre_rst_hold: valid=%b retire=%0d expected 1/1", instr_valid, retire_count); end
        instr_accept = 1'b0; rst = 1'b1;
        tick();
        checks++; if ({instr_valid, imem_req} !== 2'b00 || instr !== 32'd0 || retire_count !== 32'd0 || pc !== 32'h0040_0000) begin errors++;
            $display("FAIL rst_in_hold: valid=%b req=%b instr=%h retire=%0d pc=%h", instr_valid, imem_req, instr, retire_count, pc); end
        rst = 1'b0; imem_rdata = 32'h0000_1234;
        tick();
        checks++; if (imem_req !== 1'b1 || instr !== 32'd0) begin errors++;
            $display("FAIL idle_ack_ignored: req=%b instr=%h expected 1/00000000", imem_req, instr); end
        rst = 1'b1;
        tick();
        checks++; if ({instr_valid, imem_req} !== 2'b00 || instr !== 32'd0) begin errors++;
            $display("FAIL rst_in_fetch: valid=%b req=%b instr=%h expected 0/0/0", instr_valid, imem_req, instr); end
        rst = 1'b0; imem_ack = 1'b0;
        tick(); tick();
        checks++; if (imem_req !== 1'b1 || instr !== 32'd0) begin errors++;
            $display("FAIL ack_discarded: req=%b instr=%h expected 1/00000000", imem_req, instr); end
    endtask

    task automatic test_accept_in_fetch();
        do_reset();
        tick();
        instr_accept = 1'b1; pcsrc = 1'b1;
        tick();
        checks++; if (pc !== 32'h0040_0000 || retire_count !== 32'd0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL accept_in_fetch: pc=%h retire=%0d req=%b valid=%b", pc, retire_count, imem_req, instr_valid); end
        instr_accept = 1'b0; pcsrc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_accept_in_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage for the MIPS core. Holds the PC and issues word reads to instruction memory over a req/ack handshake. It presents the fetched instruction (plus opcode/funct slices) to the control unit and datapath. On instruction retirement it computes the next PC from the control unit's pcsrc/jump outputs, using the held instruction's immediate and target fields.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset; must be word aligned.
TIMEOUT_CYCLES, 16, max cycles waiting for imem_ack before fatal error; 0 disables timeout.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  read request; held high until ack
imem_addr  output  32  byte address of request (= pc), stable while imem_req high
imem_ack  input  1  read data valid this cycle
imem_rdata  input  32  instruction word, sampled when imem_req & imem_ack
instr  output  32  held instruction
opcode  output  6  instr[31:26]
funct  output  6  instr[5:0]
instr_valid  output  1  instr/pc valid for execution
instr_accept  input  1  core retires current instruction this cycle
pcsrc  input  1  branch taken (from control unit); sampled only on accept
jump  input  1  jump (from control unit); sampled only on accept
pc  output  32  address of held instruction
pc_plus4  output  32  pc + 4 (mod 2^32)
retire_count  output  32  retired-instruction counter, wraps
fetch_err  output  1  sticky timeout error

Behaviour:
- Reset (rst high at edge): pc=RESET_PC, instr=0, state=IDLE, wait counter=0, retire_count=0, fetch_err=0. Outputs while in IDLE: imem_req=0, instr_valid=0. Reset is honoured in any state, mid-wait or mid-hold; an in-flight ack in the reset cycle is discarded.
- States: IDLE, FETCH, HOLD, ERR; state register drives imem_req (FETCH only) and instr_valid (HOLD only).
- IDLE: unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ack=1: instr<=imem_rdata, counter<=0, -> HOLD.
  - Else: counter increments.
  - TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 without ack: -> ERR, fetch_err<=1.
  - Ack in the same cycle as the limit: ack wins, no error.
  - Minimum latency: ack in first FETCH cycle -> instr_valid the following cycle.
- HOLD: instr_valid=1; instr, pc, opcode, funct stable. pcsrc/jump ignored unless instr_accept=1. On instr_accept=1:
  - pc <= next_pc.
  - retire_count <= retire_count+1, wrapping at 2^32.
  - -> FETCH; instr retains its old value but instr_valid drops.
- next_pc priority: jump > pcsrc > sequential.
  - Jump target: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch target: pc_plus4 + (sign_extend(instr[15:0]) << 2), 32-bit modulo.
  - Otherwise: pc_plus4.
- Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000; all arithmetic mod 2^32.
- ERR: imem_req=0, instr_valid=0, fetch_err=1; exits only via rst. instr_accept, imem_ack, pcsrc and jump are ignored.
- imem_addr equals pc in all states; it is only meaningful while imem_req=1.
- No outstanding-request overlap: at most one request in flight. An ack arriving while imem_req=0 is ignored.

Test Plan:
- Reset then imem_ack tied high, rdata=32'h0000_0020, accept every HOLD cycle -> pc sequence 0x00400000, 0x00400004, 0x00400008; instr_valid high one cycle of every two; retire_count 1,2,3.
- At pc=0x00400000 fetch beq 32'h1000_0003, assert pcsrc=1 with accept -> next imem_addr=0x00400010. Repeat with imm 0xFFFF -> next imem_addr=0x00400000.
- Fetch 32'h0810_0008, jump=1 and pcsrc=1 simultaneously with accept -> imem_addr=0x00400020 (jump priority).
- Hold imem_ack low 15 cycles, ack on 16th -> no error, HOLD reached. Hold ack low 16 cycles -> fetch_err=1, imem_req=0 thereafter; later ack ignored; rst restores pc=0x00400000 and fetch_err=0.
- Force pc to 0xFFFF_FFFC via RESET_PC, sequential accept -> imem_addr=0x0000_0000. Assert rst during HOLD and in a FETCH cycle with ack -> IDLE, instr_valid=0, instr=0, retire_count=0.
- instr_accept pulsed during FETCH with pcsrc=1 -> ignored, pc unchanged, retire_count unchanged.
